time_display: RTL and testbench

TIME_DISPLAY -- requirements
Module: time_display

---
 rtl/time_display_pkg.sv | 38 +++
 rtl/time_display_bin2bcd_seq.sv | 49 ++++
 rtl/time_display.sv | 151 +++++++++++++++
 tb/tb_time_display.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/time_display_pkg.sv
// Shared FSM encoding, segment table and limits for the time_display block.
package time_display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t CONV_HW = 2'd1;
    localparam state_t CONV_CR = 2'd2;
    localparam state_t LOAD    = 2'd3;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SAT_LIMIT  = 7'd99;
    localparam int         CONV_STEPS = 7;

    function automatic logic [6:0] saturate(input logic [6:0] value);
        return (value > SAT_LIMIT) ? SAT_LIMIT : value;
    endfunction

    // Active-low patterns, bit order gfedcba.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/time_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary (<=99) to two BCD digits,
// one bit per cycle MSB first; the start edge performs the first step.
module bin2bcd_seq
    import time_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic [7:0] bcd,
    output logic       done
);

    localparam logic [2:0] LAST = 3'(CONV_STEPS);

    logic [6:0] shift_q;
    logic [2:0] step_q;

    function automatic logic [7:0] dabble(input logic [7:0] acc, input logic bit_in);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = acc[7:4];
        ones = acc[3:0];
        if (tens >= 4'd5) tens = tens + 4'd3;
        if (ones >= 4'd5) ones = ones + 4'd3;
        return {tens[2:0], ones, bit_in};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd     <= 8'd0;
            shift_q <= 7'd0;
            step_q  <= 3'd0;
        end else if (start) begin
            bcd     <= dabble(8'd0, bin[6]);
            shift_q <= {bin[5:0], 1'b0};
            step_q  <= 3'd1;
        end else if (step_q != 3'd0 && step_q != LAST) begin
            bcd     <= dabble(bcd, shift_q[6]);
            shift_q <= {shift_q[5:0], 1'b0};
            step_q  <= step_q + 3'd1;
        end
    end

    assign done = (step_q == LAST);

endmodule

// File: rtl/time_display.sv
// Dual two-digit countdown display: converts highway and country-road times to
// BCD and multiplexes them onto four active-low 7-segment digits.
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int FLAG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] hw_time,
    input  logic [6:0] cr_time,
    input  logic       hw_time_out,
    input  logic       cr_time_out,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam logic [2:0]  LAST_STEP = 3'(CONV_STEPS - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  FLAG_LOAD = 8'(FLAG_LEN);

    state_t      state_q;
    logic [2:0]  step_q;
    logic [6:0]  hw_snap_q;
    logic [6:0]  cr_snap_q;
    logic [7:0]  hw_bcd_q;
    logic [15:0] digits_q;
    logic [15:0] scan_cnt_q;
    logic [1:0]  digit_idx_q;
    logic [7:0]  hw_flag_q;
    logic [7:0]  cr_flag_q;

    logic        conv_start;
    logic        conv_done;
    logic [6:0]  conv_bin;
    logic [7:0]  conv_bcd;

    logic [3:0]  cur_digit;
    logic [6:0]  next_seg;
    logic        next_dp;
    logic [3:0]  next_an;

    // The single converter is restarted on the first cycle of each CONV state.
    assign conv_start = ((state_q == CONV_HW) || (state_q == CONV_CR)) && (step_q == 3'd0);
    assign conv_bin   = (state_q == CONV_HW) ? hw_snap_q : cr_snap_q;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // NOTE: every register here has an async reset; there are no memory arrays
    // whose reset would block RAM inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            hw_snap_q <= 7'd0;
            cr_snap_q <= 7'd0;
            hw_bcd_q  <= 8'd0;
            digits_q  <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    hw_snap_q <= saturate(hw_time);
                    cr_snap_q <= saturate(cr_time);
                    step_q    <= 3'd0;
                    state_q   <= CONV_HW;
                end
                CONV_HW: begin
                    if (step_q == LAST_STEP) begin
                        step_q  <= 3'd0;
                        state_q <= CONV_CR;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                CONV_CR: begin
                    if (step_q == 3'd0 && conv_done) hw_bcd_q <= conv_bcd;
                    if (step_q == LAST_STEP) begin
                        step_q  <= 3'd0;
                        state_q <= LOAD;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                default: begin
                    // All four digits change on one edge, so no mixed frame is shown.
                    if (conv_done) digits_q <= {hw_bcd_q, conv_bcd};
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= 16'd0;
            digit_idx_q <= 2'd3;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q  <= 16'd0;
            digit_idx_q <= digit_idx_q - 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_flag_q <= 8'd0;
            cr_flag_q <= 8'd0;
        end else begin
            if (hw_time_out)            hw_flag_q <= FLAG_LOAD;
            else if (hw_flag_q != 8'd0) hw_flag_q <= hw_flag_q - 8'd1;
            if (cr_time_out)            cr_flag_q <= FLAG_LOAD;
            else if (cr_flag_q != 8'd0) cr_flag_q <= cr_flag_q - 8'd1;
        end
    end

    // NOTE: each combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cur_digit = digits_q[{digit_idx_q, 2'b00} +: 4];
        next_seg  = digit_to_seg(cur_digit);
        if (digit_idx_q[0] && cur_digit == 4'd0) next_seg = SEG_BLANK;
        next_dp = 1'b1;
        if (digit_idx_q == 2'd2 && hw_flag_q != 8'd0) next_dp = 1'b0;
        if (digit_idx_q == 2'd0 && cr_flag_q != 8'd0) next_dp = 1'b0;
        next_an = ~(4'b0001 << digit_idx_q);
    end

    // Registered outputs keep the pins glitch-free and inactive during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= next_seg;
            dp  <= next_dp;
            an  <= next_an;
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display: stimulus queues per-cycle expected
// an/seg/dp values, a monitor pops and compares them after each rising edge.
module tb_time_display;

    localparam int SCAN_DIV = 4;
    localparam int FLAG_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] hw_time;
    logic [6:0] cr_time;
    logic       hw_time_out;
    logic       cr_time_out;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    time_display #(.SCAN_DIV(SCAN_DIV), .FLAG_LEN(FLAG_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hw_time     (hw_time),
        .cr_time     (cr_time),
        .hw_time_out (hw_time_out),
        .cr_time_out (cr_time_out),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         when;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   base_cyc = 1 << 30;
    int   hw_lo1 = 0, hw_hi1 = -1, hw_lo2 = 0, hw_hi2 = -1, cr_lo = 0, cr_hi = -1;

    // Directed vectors: inputs and hand-derived digits {hw tens, hw ones, cr tens, cr ones}.
    int vec_hw [5] = '{59, 7, 120, 99, 38};
    int vec_cr [5] = '{69, 0, 100, 10, 42};
    int vec_d  [5][4] = '{'{5, 9, 6, 9}, '{0, 7, 0, 0}, '{9, 9, 9, 9}, '{9, 9, 1, 0}, '{3, 8, 4, 2}};

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit hw_active(input int c);
        return (c >= hw_lo1 && c <= hw_hi1) || (c >= hw_lo2 && c <= hw_hi2);
    endfunction

    function automatic bit cr_active(input int c);
        return (c >= cr_lo && c <= cr_hi);
    endfunction

    // Frame m covers the 16 cycles after release-relative edges 16m+1..16m+16.
    task automatic push_frame(input int m, input int ht, input int ho, input int ct, input int co);
        exp_t e;
        int   slot;
        int   d;
        for (int k = 1; k <= 16; k++) begin
            slot = 3 - (((16 * m + k - 1) / 4) % 4);
            case (slot)
                3:       d = ht;
                2:       d = ho;
                1:       d = ct;
                default: d = co;
            endcase
            e.when = base_cyc + 16 * m + k;
            e.an   = ~(4'b0001 << slot);
            e.seg  = ((slot == 3 || slot == 1) && d == 0) ? 7'b1111111 : seg_of(d);
            e.dp   = !((slot == 2 && hw_active(e.when)) || (slot == 0 && cr_active(e.when)));
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        exp_t item;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n === 1'b1 && cyc > base_cyc)
                check("an_onehot", 16'($countones(~an)), 16'd1);
            while (sb_q.size() > 0 && sb_q[0].when <= cyc) begin
                item = sb_q.pop_front();
                if (item.when < cyc) begin
                    check("missed_sample", 16'(item.when), 16'(cyc));
                end else begin
                    check("an",  16'(an),  16'(item.an));
                    check("seg", 16'(seg), 16'(item.seg));
                    check("dp",  16'(dp),  16'(item.dp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r1;
        rst_n       = 1'b0;
        hw_time     = 7'(vec_hw[0]);
        cr_time     = 7'(vec_cr[0]);
        hw_time_out = 1'b0;
        cr_time_out = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an",  16'(an),  16'b1111);
        check("reset_seg", 16'(seg), 16'b1111111);
        check("reset_dp",  16'(dp),  16'd1);

        @(negedge clk);
        base_cyc = cyc;
        r1       = cyc;
        rst_n    = 1'b1;
        hw_lo1 = r1 + 91;  hw_hi1 = r1 + 116;
        hw_lo2 = r1 + 131; hw_hi2 = r1 + 146;
        cr_lo  = r1 + 131; cr_hi  = r1 + 146;

        push_frame(0, 0, 0, 0, 0);
        push_frame(1, vec_d[0][0], vec_d[0][1], vec_d[0][2], vec_d[0][3]);
        for (int i = 1; i < 5; i++) begin
            wait_until(r1 + 16 * i - 8);
            hw_time = 7'(vec_hw[i]);
            cr_time = 7'(vec_cr[i]);
            if (i < 4) begin
                push_frame(i + 1, vec_d[i][0], vec_d[i][1], vec_d[i][2], vec_d[i][3]);
            end else begin
                for (int m = 5; m <= 9; m++)
                    push_frame(m, vec_d[4][0], vec_d[4][1], vec_d[4][2], vec_d[4][3]);
            end
        end

        // hw pulse, retrigger 10 cycles later, then simultaneous hw+cr pulses.
        wait_until(r1 + 89);
        hw_time_out = 1'b1;
        @(negedge clk);
        hw_time_out = 1'b0;
        wait_until(r1 + 99);
        hw_time_out = 1'b1;
        @(negedge clk);
        hw_time_out = 1'b0;
        wait_until(r1 + 129);
        hw_time_out = 1'b1;
        cr_time_out = 1'b1;
        @(negedge clk);
        hw_time_out = 1'b0;
        cr_time_out = 1'b0;

        // New inputs after the IDLE sample, then reset during CONV_CR.
        wait_until(r1 + 162);
        hw_time = 7'd21;
        cr_time = 7'd84;
        wait_until(r1 + 170);
        rst_n = 1'b0;
        #1;
        check("midreset_an",  16'(an),  16'b1111);
        check("midreset_seg", 16'(seg), 16'b1111111);
        check("midreset_dp",  16'(dp),  16'd1);
        repeat (3) @(negedge clk);
        base_cyc = cyc;
        rst_n    = 1'b1;
        push_frame(0, 0, 0, 0, 0);
        push_frame(1, 2, 1, 8, 4);
        wait_until(base_cyc + 34);

        for (int n = 0; n < 100 && sb_q.size() > 0; n++) @(negedge clk);
        check("scoreboard_drain", 16'(sb_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
